ram_peek_dumper: RTL and testbench
==================================

# ram_peek_dumper

Read-out engine for a node's local RAM through its peek port. On a start pulse it sweeps a contiguous word range, reading each word via `peekAddress`/`peekData` without disturbing the core's port, and serialises every 32-bit word into a byte stream (MSB first) with valid/ready handshake toward the board UART transmitter. It sits directly downstream of the RAM's peek port and replaces simulation-only `$writememh` dumps of output chunks (nodes 6–10) on hardware.

## Interface
- `RAM_SIZE`, 1024: words in the attached RAM; addresses wrap modulo this value; power of two.
- `LEN_W`, 16: width of `word_count`.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  synchronous reset, active-high (asserted = 1), sampled on `clk` only.
- `start`  in  1  one-cycle request; honoured only in IDLE.
- `start_addr`  in  32  first word address; sampled with `start`.
- `word_count`  in  LEN_W  words to dump; sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the last byte is accepted.
- `peekAddress`  out  32  registered address to the RAM peek port.
- `peekData`  in  32  RAM peek read data, one-cycle latency after `peekAddress`.
- `m_data`  out  8  stream byte.
- `m_valid`  out  1  stream byte valid.
- `m_ready`  in  1  downstream accepts byte when `m_valid && m_ready`.

## Operation
- Reset values: `busy`=0, `done`=0, `m_valid`=0, `m_data`=0, `peekAddress`=0, state IDLE, counters 0.
- States: IDLE, FETCH, CAPTURE, SEND, (CSUM with macro), FINISH.
- IDLE: on `start`, latch `word_count` into remaining counter; if it is 0, go FINISH. Otherwise set `peekAddress <= start_addr mod RAM_SIZE` and go FETCH.
- FETCH: one cycle; the RAM registers `ram[peekAddress]`. Go CAPTURE.
- CAPTURE: load `peekData` into a 32-bit shift register, set `m_data <= peekData[31:24]`, `m_valid <= 1`, byte index 0. Go SEND.
- SEND: on handshake, advance the byte index. Bytes are sent MSB first: [31:24], [23:16], [15:8], [7:0].
- SEND, after the 4th byte's handshake: drop `m_valid` and decrement remaining. If remaining is now 0, go FINISH (CSUM with the macro). Otherwise `peekAddress <= (peekAddress+1) mod RAM_SIZE`, go FETCH.
- FINISH: pulse `done`, clear `busy`, go IDLE.
- Stream rule: while `m_valid && !m_ready`, `m_data` and `m_valid` stay stable. `m_valid` never depends combinationally on `m_ready`.
- Address wrap: `start_addr + k` is reduced modulo `RAM_SIZE`. Upper address bits of `start_addr` are ignored; `peekAddress[31:log2(RAM_SIZE)]` is always 0.
- `start` while busy: ignored; the in-flight dump is unaffected.
- Reset mid-dump: the next cycle shows `m_valid`=0, `busy`=0, no `done` pulse, and the partial word is discarded.

## Timing
- `start` sampled at edge E0. Then `busy`=1 and `peekAddress` valid after E0; RAM samples at E1; capture at E2; first `m_valid` visible after E2 (3-cycle start-to-first-byte latency).
- With `m_ready` held at 1: 6 cycles per word (FETCH, CAPTURE, 4× SEND).
- `done` asserts the cycle after the last byte handshake. `busy` falls in the same cycle as `done`. A new `start` is accepted the following cycle.
- `word_count`=0: `done` pulses the cycle after E0 and no bytes are emitted.

## Configuration
- `RAM_DUMP_CHECKSUM_EN` defined: after the final word, state CSUM emits one extra byte. The byte is the XOR of all dumped data bytes, with the same handshake rule. `done` follows its acceptance. Not sent when `word_count`=0.
- Undefined: no CSUM state and no checksum logic; the stream contains exactly 4×`word_count` bytes.

## Test plan
- RAM[0x10]=0xDEADBEEF, start_addr=0x10, count=1, `m_ready`=1 -> bytes DE,AD,BE,EF on cycles 3–6 after start; `done` on cycle 7; `peekAddress`=0x10.
- start_addr=0x3FF, count=2, RAM[0x3FF]=0x11223344, RAM[0]=0x55667788 -> bytes 11..44 then 55..88; `peekAddress` wraps to 0.
- `m_ready` toggling 1,0,0,1 on a 1-word dump -> `m_data` holds during stalls; exactly 4 handshakes; no duplicate or dropped bytes.
- count=0 -> `done` one cycle after start; `m_valid` never asserts. Then a `start` pulse mid-dump -> ignored and byte total unchanged.
- `rst_n`=1 for one cycle during the 2nd byte of word 3 of 5 -> `m_valid`=0 and `busy`=0 next cycle, no `done`. A fresh start then dumps correctly.
- With `RAM_DUMP_CHECKSUM_EN`, words 0x01020304 and 0x000000FF -> 8 data bytes followed by checksum byte 0xFB.

Source files
------------

// File: rtl/ram_peek_dumper.sv
// Purpose: sweeps a word range of the local RAM through its peek port and streams every word as 4 bytes, MSB first.
// Latency: 3 cycles start-to-first-byte; 6 cycles per word with m_ready held high; done the cycle after the last byte.
// Backpressure: m_valid/m_data hold while m_ready is low; m_valid is registered and never depends on m_ready.
// Option: define RAM_DUMP_CHECKSUM_EN to append one XOR checksum byte after the final data byte.
module ram_peek_dumper #(
   parameter int RAM_SIZE = 1024,
   parameter int LEN_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,        // synchronous, active-high
   input  logic             start,
   input  logic [31:0]      start_addr,
   input  logic [LEN_W-1:0] word_count,
   output logic             busy,
   output logic             done,
   output logic [31:0]      peekAddress,
   input  logic [31:0]      peekData,
   output logic [7:0]       m_data,
   output logic             m_valid,
   input  logic             m_ready
);

   localparam int AW = $clog2(RAM_SIZE);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_CAPTURE,
      S_SEND,
`ifdef RAM_DUMP_CHECKSUM_EN
      S_CSUM,
`endif
      S_FINISH
   } state_t;

   state_t           state;
   logic [LEN_W-1:0] remaining;
   logic [31:0]      shreg;       // bytes still to send, left-aligned
   logic [1:0]       byte_idx;
`ifdef RAM_DUMP_CHECKSUM_EN
   logic [7:0]       csum;
`endif

   logic             hs;
   logic [AW-1:0]    addr_inc;
   logic [LEN_W-1:0] one_len;
   logic             unused_addr_hi;

   // Address arithmetic stays inside the RAM's index width so wrap is free.
   assign hs             = m_valid && m_ready;
   assign addr_inc       = peekAddress[AW-1:0] + {{(AW-1){1'b0}}, 1'b1};
   assign one_len        = {{(LEN_W-1){1'b0}}, 1'b1};
   assign unused_addr_hi = ^start_addr[31:AW];

   // Single FSM: fetch a word, capture it, shift it out a byte per handshake.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state       <= S_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         m_valid     <= 1'b0;
         m_data      <= 8'h00;
         peekAddress <= 32'h0;
         remaining   <= '0;
         shreg       <= 32'h0;
         byte_idx    <= 2'd0;
`ifdef RAM_DUMP_CHECKSUM_EN
         csum        <= 8'h00;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  remaining <= word_count;
                  if (word_count == '0) begin
                     // Empty dump: finish immediately, never raise busy.
                     done  <= 1'b1;
                     state <= S_FINISH;
                  end else begin
                     busy        <= 1'b1;
                     peekAddress <= {{(32-AW){1'b0}}, start_addr[AW-1:0]};
`ifdef RAM_DUMP_CHECKSUM_EN
                     csum        <= 8'h00;
`endif
                     state       <= S_FETCH;
                  end
               end
            end

            S_FETCH: begin
               // RAM registers ram[peekAddress] on this edge.
               state <= S_CAPTURE;
            end

            S_CAPTURE: begin
               shreg    <= {peekData[23:0], 8'h00};
               m_data   <= peekData[31:24];
               m_valid  <= 1'b1;
               byte_idx <= 2'd0;
               state    <= S_SEND;
            end

            S_SEND: begin
               if (hs) begin
`ifdef RAM_DUMP_CHECKSUM_EN
                  csum <= csum ^ m_data;
`endif
                  if (byte_idx == 2'd3) begin
                     m_valid   <= 1'b0;
                     remaining <= remaining - one_len;
                     if (remaining == one_len) begin
`ifdef RAM_DUMP_CHECKSUM_EN
                        state <= S_CSUM;
`else
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_FINISH;
`endif
                     end else begin
                        peekAddress <= {{(32-AW){1'b0}}, addr_inc};
                        state       <= S_FETCH;
                     end
                  end else begin
                     m_data   <= shreg[31:24];
                     shreg    <= shreg << 8;
                     byte_idx <= byte_idx + 2'd1;
                  end
               end
            end

`ifdef RAM_DUMP_CHECKSUM_EN
            S_CSUM: begin
               // First cycle presents the checksum, then wait for its handshake.
               if (!m_valid) begin
                  m_data  <= csum;
                  m_valid <= 1'b1;
               end else if (m_ready) begin
                  m_valid <= 1'b0;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state   <= S_FINISH;
               end
            end
`endif

            S_FINISH: begin
               // done is visible during this cycle; new starts are taken from IDLE.
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Stream bytes must not change or vanish while the sink is stalling.
   property p_stall_hold;
      @(posedge clk) disable iff (rst_n)
         (m_valid && !m_ready) |=> (m_valid && $stable(m_data));
   endproperty
   a_stall_hold: assert property (p_stall_hold);

   // Address never leaves the RAM's index range.
   a_addr_range: assert property (@(posedge clk) peekAddress[31:AW] == '0);

endmodule

// File: tb/tb_ram_peek_dumper.sv
// Directed bench for ram_peek_dumper with a behavioural 1-cycle-latency peek RAM.
// Stream bytes are logged on handshakes; each scenario task checks its own results.
// Runs against the default build; checksum expectations switch on RAM_DUMP_CHECKSUM_EN.
module tb_ram_peek_dumper;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [31:0] start_addr = 32'h0;
   logic [15:0] word_count = 16'h0;
   logic        busy;
   logic        done;
   logic [31:0] peekAddress;
   logic [31:0] peekData;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_ready = 1'b0;

`ifdef RAM_DUMP_CHECKSUM_EN
   localparam int EXTRA    = 1;
   localparam int DONE_LAT = 9;
`else
   localparam int EXTRA    = 0;
   localparam int DONE_LAT = 7;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] got[$];
   int done_cnt = 0;
   logic [31:0] ram [0:1023];

   ram_peek_dumper #(.RAM_SIZE(1024), .LEN_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
      .word_count(word_count), .busy(busy), .done(done),
      .peekAddress(peekAddress), .peekData(peekData),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) peekData <= ram[peekAddress[9:0]];

   // rst_n is active-high: log only outside reset.
   always @(negedge clk) begin
      if (!rst_n) begin
         if (m_valid && m_ready) got.push_back(m_data);
         if (done) done_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      got.delete();
      done_cnt = 0;
   endtask

   task automatic pulse_start(input logic [31:0] a, input logic [15:0] n);
      start = 1'b1;
      start_addr = a;
      word_count = n;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int max, output int waited);
      waited = -1;
      for (int i = 0; i < max; i++) begin
         if (done === 1'b1) begin
            waited = i;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      repeat (3) tick();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", done); end
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %0b want 0", m_valid); end
      n_checks++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL reset_m_data: got %h want 00", m_data); end
      n_checks++; if (peekAddress !== 32'h0) begin n_fail++; $display("FAIL reset_peekAddress: got %h want 0", peekAddress); end
      rst_n = 1'b0;
      tick();
   endtask

   task automatic test_single();
      logic [31:0] w;
      logic        ev;
      logic [7:0]  ed;
      int          waited;
      w = 32'hDEADBEEF;
      ram[16] = w;
      m_ready = 1'b1;
      clear_log();
      pulse_start(32'h10, 16'd1);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_c1: got %0b want 1", busy); end
      n_checks++; if (peekAddress !== 32'h10) begin n_fail++; $display("FAIL single_peekAddress: got %h want 10", peekAddress); end
      for (int c = 1; c <= 6; c++) begin
         ev = (c >= 3);
         ed = 8'(w >> (8 * (6 - c)));
         n_checks++;
         if (m_valid !== ev || (ev && m_data !== ed)) begin
            n_fail++;
            $display("FAIL single_cycle%0d: got v=%0b d=%h want v=%0b d=%h", c, m_valid, m_data, ev, ed);
         end
         tick();
      end
      wait_done(20, waited);
      n_checks++; if (waited < 0 || 7 + waited != DONE_LAT) begin n_fail++; $display("FAIL single_done_cycle: got %0d want %0d", 7 + waited, DONE_LAT); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_at_done: got %0b want 0", busy); end
      tick();
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse: got %0b want 0", done); end
      n_checks++; if (got.size() != 4 + EXTRA || done_cnt != 1) begin n_fail++; $display("FAIL single_counts: got bytes=%0d done=%0d want %0d/1", got.size(), done_cnt, 4 + EXTRA); end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (got[i] !== 8'(w >> (8 * (3 - i)))) begin n_fail++; $display("FAIL single_byte%0d: got %h want %h", i, got[i], 8'(w >> (8 * (3 - i)))); end
      end
   endtask

   task automatic test_wrap();
      logic [7:0] exp[8];
      logic hi_bad, saw_zero;
      int waited;
      exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      ram[1023] = 32'h11223344;
      ram[0]    = 32'h55667788;
      m_ready = 1'b1;
      clear_log();
      pulse_start(32'hABCD_F3FF, 16'd2);
      n_checks++; if (peekAddress !== 32'h3FF) begin n_fail++; $display("FAIL wrap_first_addr: got %h want 3ff", peekAddress); end
      hi_bad = 1'b0;
      saw_zero = 1'b0;
      waited = -1;
      for (int i = 0; i < 40; i++) begin
         if (peekAddress[31:10] != 22'h0) hi_bad = 1'b1;
         if (peekAddress == 32'h0) saw_zero = 1'b1;
         if (done === 1'b1) begin waited = i; break; end
         tick();
      end
      n_checks++; if (waited < 0) begin n_fail++; $display("FAIL wrap_done_timeout: got none want done"); end
      n_checks++; if (hi_bad || !saw_zero) begin n_fail++; $display("FAIL wrap_addr: got hi_bad=%0b wrapped=%0b want 0/1", hi_bad, saw_zero); end
      tick();
      n_checks++; if (got.size() != 8 + EXTRA) begin n_fail++; $display("FAIL wrap_count: got %0d want %0d", got.size(), 8 + EXTRA); end
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (got[i] !== exp[i]) begin n_fail++; $display("FAIL wrap_byte%0d: got %h want %h", i, got[i], exp[i]); end
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] exp[4];
      logic [3:0] pat;
      logic       pv, pr;
      logic [7:0] pd;
      int i;
      exp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      pat = 4'b1001;
      ram[32] = 32'hA1B2C3D4;
      m_ready = 1'b0;
      clear_log();
      pulse_start(32'h20, 16'd1);
      i = 0;
      while (m_valid !== 1'b1 && i < 10) begin tick(); i++; end
      n_checks++; if (m_valid !== 1'b1 || m_data !== 8'hA1) begin n_fail++; $display("FAIL bp_first: got v=%0b d=%h want 1/a1", m_valid, m_data); end
      i = 0;
      while (done !== 1'b1 && i < 30) begin
         m_ready = (i < 4) ? pat[i] : 1'b1;
         pv = m_valid; pr = m_ready; pd = m_data;
         tick();
         if (pv && !pr) begin
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== pd) begin n_fail++; $display("FAIL bp_stall_hold: got v=%0b d=%h want 1/%h", m_valid, m_data, pd); end
         end
         i++;
      end
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL bp_done_timeout: got %0b want 1", done); end
      tick();
      n_checks++; if (got.size() != 4 + EXTRA || done_cnt != 1) begin n_fail++; $display("FAIL bp_counts: got bytes=%0d done=%0d want %0d/1", got.size(), done_cnt, 4 + EXTRA); end
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (got[k] !== exp[k]) begin n_fail++; $display("FAIL bp_byte%0d: got %h want %h", k, got[k], exp[k]); end
      end
      m_ready = 1'b1;
   endtask

   task automatic test_zero_and_ignore();
      logic [7:0] exp[8];
      int waited;
      exp = '{8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h01, 8'h23, 8'h45, 8'h67};
      m_ready = 1'b1;
      clear_log();
      pulse_start(32'h10, 16'd0);
      n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_done: got done=%0b busy=%0b want 1/0", done, busy); end
      tick();
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_pulse: got %0b want 0", done); end
      repeat (4) tick();
      n_checks++; if (got.size() != 0 || done_cnt != 1) begin n_fail++; $display("FAIL zero_no_bytes: got bytes=%0d done=%0d want 0/1", got.size(), done_cnt); end

      ram[64] = 32'hCAFEF00D;
      ram[65] = 32'h01234567;
      ram[128] = 32'hFFFFFFFF;
      clear_log();
      pulse_start(32'h40, 16'd2);
      repeat (3) tick();
      pulse_start(32'h80, 16'd3);
      wait_done(60, waited);
      n_checks++; if (waited < 0) begin n_fail++; $display("FAIL ignore_done_timeout: got none want done"); end
      repeat (12) tick();
      n_checks++; if (busy !== 1'b0 || done_cnt != 1 || got.size() != 8 + EXTRA) begin n_fail++; $display("FAIL ignore_counts: got busy=%0b done=%0d bytes=%0d want 0/1/%0d", busy, done_cnt, got.size(), 8 + EXTRA); end
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (got[i] !== exp[i]) begin n_fail++; $display("FAIL ignore_byte%0d: got %h want %h", i, got[i], exp[i]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp[4];
      int waited;
      exp = '{8'h13, 8'h57, 8'h9B, 8'hDF};
      ram[80] = 32'h13579BDF;
      m_ready = 1'b1;
      clear_log();
      pulse_start(32'h10, 16'd1);
      wait_done(30, waited);
      n_checks++; if (waited < 0) begin n_fail++; $display("FAIL b2b_first_timeout: got none want done"); end
      tick();
      clear_log();
      pulse_start(32'h50, 16'd1);
      n_checks++; if (busy !== 1'b1 || peekAddress !== 32'h50) begin n_fail++; $display("FAIL b2b_accept: got busy=%0b addr=%h want 1/50", busy, peekAddress); end
      wait_done(30, waited);
      tick();
      n_checks++; if (got.size() != 4 + EXTRA) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", got.size(), 4 + EXTRA); end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (got[i] !== exp[i]) begin n_fail++; $display("FAIL b2b_byte%0d: got %h want %h", i, got[i], exp[i]); end
      end
   endtask

   task automatic test_reset_mid();
      logic found;
      int waited;
      for (int k = 0; k < 5; k++) ram[256 + k] = {4'(k + 1), 4'hA, 4'(k + 1), 4'hB, 4'(k + 1), 4'hC, 4'(k + 1), 4'hD};
      m_ready = 1'b1;
      clear_log();
      pulse_start(32'h100, 16'd5);
      found = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (m_valid === 1'b1 && got.size() == 9) begin found = 1'b1; break; end
         tick();
      end
      n_checks++; if (!found || m_data !== 8'h3B) begin n_fail++; $display("FAIL rstmid_reach: got found=%0b d=%h want 1/3b", found, m_data); end
      rst_n = 1'b1;
      tick();
      n_checks++; if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rstmid_after: got v=%0b busy=%0b done=%0b want 0/0/0", m_valid, busy, done); end
      rst_n = 1'b0;
      repeat (6) tick();
      n_checks++; if (done_cnt != 0 || got.size() != 9 || m_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet: got done=%0d bytes=%0d v=%0b want 0/9/0", done_cnt, got.size(), m_valid); end
      clear_log();
      pulse_start(32'h10, 16'd1);
      wait_done(30, waited);
      tick();
      n_checks++; if (got.size() != 4 + EXTRA || got[0] !== 8'hDE || got[3] !== 8'hEF) begin n_fail++; $display("FAIL rstmid_fresh: got n=%0d b0=%h b3=%h want %0d/de/ef", got.size(), got[0], got[3], 4 + EXTRA); end
   endtask

`ifdef RAM_DUMP_CHECKSUM_EN
   task automatic test_checksum();
      int waited;
      ram[512] = 32'h01020304;
      ram[513] = 32'h000000FF;
      m_ready = 1'b1;
      clear_log();
      pulse_start(32'h200, 16'd2);
      wait_done(40, waited);
      tick();
      n_checks++; if (got.size() != 9 || got[8] !== 8'hFB) begin n_fail++; $display("FAIL csum_byte: got n=%0d b8=%h want 9/fb", got.size(), got[8]); end
   endtask
`endif

   initial begin
      for (int a = 0; a < 1024; a++) ram[a] = 32'h0;
      test_reset();
      test_single();
      test_wrap();
      test_backpressure();
      test_zero_and_ignore();
      test_back_to_back();
      test_reset_mid();
`ifdef RAM_DUMP_CHECKSUM_EN
      test_checksum();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
